// File: rtl/cordic_core.sv
// cordic_core: pipelined CORDIC rotator/vectorer with a valid/ready stream interface.
// Ports: clk, rst_n (async active-low); in_valid/in_ready, mode (0 rotation, 1 vectoring),
//        x_in/y_in (DATA_W signed), z_in (binary angle, 2^32 = 2*pi);
//        out_valid/out_ready, out_mode, x_out/y_out (W signed), z_out.
// Macro CORDIC_GAIN_COMP_EN adds a K-scaling output stage (latency STAGES+2 instead of STAGES+1).
module cordic_core #(
  parameter int DATA_W = 16,
  parameter int EXTRA_BITS = 6,
  parameter int STAGES = 16,
  localparam int PHASE_W = 32,
  localparam int W = DATA_W + EXTRA_BITS + 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mode,
  input  logic signed [DATA_W-1:0]  x_in,
  input  logic signed [DATA_W-1:0]  y_in,
  input  logic        [PHASE_W-1:0] z_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_mode,
  output logic signed [W-1:0]       x_out,
  output logic signed [W-1:0]       y_out,
  output logic        [PHASE_W-1:0] z_out
);
  localparam logic [31:0] ATAN [0:30] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4, 32'h028B0D43, 32'h0145D7E1,
    32'h00A2F61E, 32'h00517C55, 32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D, 32'h000028BE, 32'h0000145F,
    32'h00000A30, 32'h00000518, 32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005, 32'h00000003, 32'h00000001,
    32'h00000001};
  logic                      w_adv;
  logic                      w_pos90;
  logic                      w_neg90;
  logic signed [W-1:0]       w_xs;
  logic signed [W-1:0]       w_ys;
  logic signed [W-1:0]       w_x0;
  logic signed [W-1:0]       w_y0;
  logic        [PHASE_W-1:0] w_z0;
  logic signed [W-1:0]       w_xn [1:STAGES];
  logic signed [W-1:0]       w_yn [1:STAGES];
  logic        [PHASE_W-1:0] w_zn [1:STAGES];
  logic signed [W-1:0]       r_x [0:STAGES];
  logic signed [W-1:0]       r_y [0:STAGES];
  logic        [PHASE_W-1:0] r_z [0:STAGES];
  logic        [STAGES:0]    r_v;
  logic        [STAGES:0]    r_m;

  // Whole pipeline moves together; it only freezes when a result is waiting unaccepted.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  // Two guard bits above the sign let the pre-rotation negate the most negative input.
  assign w_xs = {{(W-DATA_W){x_in[DATA_W-1]}}, x_in} << EXTRA_BITS;
  assign w_ys = {{(W-DATA_W){y_in[DATA_W-1]}}, y_in} << EXTRA_BITS;
  // Coarse +/-90 degree step brings the problem into the micro-rotation convergence range.
  assign w_pos90 = mode ? (w_xs[W-1] & w_ys[W-1]) : (z_in[31:30] == 2'b01);
  assign w_neg90 = mode ? (w_xs[W-1] & ~w_ys[W-1]) : (z_in[31:30] == 2'b10);
  assign w_x0 = w_pos90 ? -w_ys : w_neg90 ? w_ys : w_xs;
  assign w_y0 = w_pos90 ? w_xs : w_neg90 ? -w_xs : w_ys;
  assign w_z0 = w_pos90 ? z_in - 32'h40000000 : w_neg90 ? z_in + 32'h40000000 : z_in;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic w_d;
    assign w_d         = r_m[i] ? r_y[i][W-1] : !r_z[i][31];
    assign w_xn[i+1]   = w_d ? r_x[i] - (r_y[i] >>> i) : r_x[i] + (r_y[i] >>> i);
    assign w_yn[i+1]   = w_d ? r_y[i] + (r_x[i] >>> i) : r_y[i] - (r_x[i] >>> i);
    assign w_zn[i+1]   = w_d ? r_z[i] - ATAN[i] : r_z[i] + ATAN[i];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k <= STAGES; k++) begin
        r_x[k] <= '0;
        r_y[k] <= '0;
        r_z[k] <= '0;
      end
      r_v <= '0;
      r_m <= '0;
    end else if (w_adv) begin
      r_x[0] <= w_x0;
      r_y[0] <= w_y0;
      r_z[0] <= w_z0;
      for (int k = 1; k <= STAGES; k++) begin
        r_x[k] <= w_xn[k];
        r_y[k] <= w_yn[k];
        r_z[k] <= w_zn[k];
      end
      r_v <= {r_v[STAGES-1:0], in_valid};
      r_m <= {r_m[STAGES-1:0], mode};
    end

`ifdef CORDIC_GAIN_COMP_EN
  // K = 1/gain in Q2.30; |x| < 2^(W-1) and K < 2^30 so the product fits in W+30 bits.
  localparam logic signed [31:0] K = 32'sh26DD3B6A;
  logic signed [W+29:0] w_px;
  logic signed [W+29:0] w_py;
  logic signed [W-1:0]  r_xo;
  logic signed [W-1:0]  r_yo;
  logic [PHASE_W-1:0]   r_zo;
  logic                 r_vo;
  logic                 r_mo;
  assign w_px = (W+30)'(r_x[STAGES]) * (W+30)'(K);
  assign w_py = (W+30)'(r_y[STAGES]) * (W+30)'(K);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_xo <= '0;
      r_yo <= '0;
      r_zo <= '0;
      r_vo <= 1'b0;
      r_mo <= 1'b0;
    end else if (w_adv) begin
      r_xo <= W'(w_px >>> 30);
      r_yo <= W'(w_py >>> 30);
      r_zo <= r_z[STAGES];
      r_vo <= r_v[STAGES];
      r_mo <= r_m[STAGES];
    end
  assign out_valid = r_vo;
  assign out_mode  = r_mo;
  assign x_out     = r_xo;
  assign y_out     = r_yo;
  assign z_out     = r_zo;
`else
  assign out_valid = r_v[STAGES];
  assign out_mode  = r_m[STAGES];
  assign x_out     = r_x[STAGES];
  assign y_out     = r_y[STAGES];
  assign z_out     = r_z[STAGES];
`endif
endmodule

// File: tb/tb_cordic_core.sv
// tb_cordic_core: directed self-checking bench for cordic_core (DATA_W=16, EXTRA_BITS=6, STAGES=16).
module tb_cordic_core;
  localparam int DATA_W = 16;
  localparam int W = DATA_W + 6 + 2;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = 18;
  localparam int R45 = 741455;
  localparam int MAG = 1048576;
  localparam int RES90 = 18;
  localparam longint GPPM = 1000000;
`else
  localparam int LAT = 17;
  localparam int R45 = 1221000;
  localparam int MAG = 1726753;
  localparam int RES90 = 30;
  localparam longint GPPM = 1646760;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic mode = 1'b0;
  logic out_ready = 1'b1;
  logic signed [DATA_W-1:0] x_in = '0;
  logic signed [DATA_W-1:0] y_in = '0;
  logic [31:0] z_in = '0;
  logic in_ready;
  logic out_valid;
  logic out_mode;
  logic signed [W-1:0] x_out;
  logic signed [W-1:0] y_out;
  logic [31:0] z_out;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cordic_core dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_mode(out_mode), .x_out(x_out), .y_out(y_out), .z_out(z_out)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Drives one sample and waits (bounded) for its result; lat = -1 if it never appears.
  task automatic run_one(input logic m, input int x, input int y, input logic [31:0] z,
                         output int lat, output int xo, output int yo, output logic [31:0] zo,
                         output logic mo);
    @(negedge clk);
    out_ready = 1'b1;
    mode = m;
    x_in = 16'(x);
    y_in = 16'(y);
    z_in = z;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      if (out_valid) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    xo = x_out;
    yo = y_out;
    zo = z_out;
    mo = out_mode;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (x_out !== '0) begin failures++; $display("FAIL reset_x_out got=%0d want=0", x_out); end
    checks++; if (y_out !== '0) begin failures++; $display("FAIL reset_y_out got=%0d want=0", y_out); end
    checks++; if (z_out !== '0) begin failures++; $display("FAIL reset_z_out got=%h want=0", z_out); end
    checks++; if (out_mode !== 1'b0) begin failures++; $display("FAIL reset_out_mode got=%b want=0", out_mode); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_rotation();
    int lat, xo, yo, dz;
    logic [31:0] zo;
    logic mo;
    run_one(1'b0, 16384, 0, 32'h20000000, lat, xo, yo, zo, mo);
    dz = int'(zo);
    checks++; if (lat != LAT) begin failures++; $display("FAIL rot45_latency got=%0d want=%0d", lat, LAT); end
    checks++; if (xo > R45 + 64 || xo < R45 - 64) begin failures++; $display("FAIL rot45_x got=%0d want=%0d+/-64", xo, R45); end
    checks++; if (yo > R45 + 64 || yo < R45 - 64) begin failures++; $display("FAIL rot45_y got=%0d want=%0d+/-64", yo, R45); end
    checks++; if (dz > 65536 || dz < -65536) begin failures++; $display("FAIL rot45_z got=%h want=0+/-2^16", zo); end
    checks++; if (mo !== 1'b0) begin failures++; $display("FAIL rot45_mode got=%b want=0", mo); end
    // -pi/2: 16 micro-rotations leave a small residual angle, about +RES90 on x.
    run_one(1'b0, 16384, 0, 32'hC0000000, lat, xo, yo, zo, mo);
    checks++; if (xo > RES90 + 64 || xo < RES90 - 64) begin failures++; $display("FAIL rotm90_x got=%0d want=%0d+/-64", xo, RES90); end
    checks++; if (yo > -MAG + 64 || yo < -MAG - 64) begin failures++; $display("FAIL rotm90_y got=%0d want=%0d+/-64", yo, -MAG); end
    run_one(1'b0, 16384, 0, 32'h60000000, lat, xo, yo, zo, mo);
    checks++; if (xo > -R45 + 64 || xo < -R45 - 64) begin failures++; $display("FAIL rot135_x got=%0d want=%0d+/-64", xo, -R45); end
    checks++; if (yo > R45 + 64 || yo < R45 - 64) begin failures++; $display("FAIL rot135_y got=%0d want=%0d+/-64", yo, R45); end
  endtask

  task automatic test_vectoring();
    int lat, xo, yo, dz;
    logic [31:0] zo;
    logic mo;
    run_one(1'b1, -16384, 0, 32'h0, lat, xo, yo, zo, mo);
    dz = int'(zo - 32'h80000000);
    checks++; if (lat != LAT) begin failures++; $display("FAIL vec_latency got=%0d want=%0d", lat, LAT); end
    checks++; if (xo > MAG + 64 || xo < MAG - 64) begin failures++; $display("FAIL vec_x got=%0d want=%0d+/-64", xo, MAG); end
    checks++; if (yo > 64 || yo < -64) begin failures++; $display("FAIL vec_y got=%0d want=0+/-64", yo); end
    checks++; if (dz > 65536 || dz < -65536) begin failures++; $display("FAIL vec_z got=%h want=80000000+/-2^16", zo); end
    checks++; if (mo !== 1'b1) begin failures++; $display("FAIL vec_mode got=%b want=1", mo); end
  endtask

  // 32 samples with x = 1000+500k, y = 0; odd k vectoring with z_in = k<<24, even k rotation by 0.
  // Both give x_out = gain*x*64, y_out ~ 0; z_out ~ z_in.
  task automatic test_back_to_back();
    int sent, rcvd, held_x, ex, dz;
    logic [31:0] ez;
    sent = 0;
    rcvd = 0;
    held_x = 0;
    for (int cyc = 0; cyc < 300 && rcvd < 32; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 20 && cyc < 25);
      in_valid = (sent < 32);
      mode = sent[0];
      x_in = 16'(1000 + 500 * sent);
      y_in = '0;
      z_in = sent[0] ? (32'(sent) << 24) : 32'h0;
      #1;
      if (!out_ready) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cyc=%0d got=%b want=0", cyc, in_ready); end
        if (cyc == 20) held_x = x_out;
        else begin
          checks++; if (int'(x_out) != held_x || out_valid !== 1'b1) begin failures++; $display("FAIL stall_hold cyc=%0d got=%0d/%b want=%0d/1", cyc, x_out, out_valid, held_x); end
        end
      end
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        ex = int'((longint'(1000 + 500 * rcvd) * 64 * GPPM) / 1000000);
        ez = rcvd[0] ? (32'(rcvd) << 24) : 32'h0;
        dz = int'(z_out - ez);
        checks++; if (out_mode !== rcvd[0]) begin failures++; $display("FAIL b2b_mode idx=%0d got=%b want=%b", rcvd, out_mode, rcvd[0]); end
        checks++; if (x_out > ex + 64 || x_out < ex - 64) begin failures++; $display("FAIL b2b_x idx=%0d got=%0d want=%0d+/-64", rcvd, x_out, ex); end
        checks++; if (y_out > 64 || y_out < -64) begin failures++; $display("FAIL b2b_y idx=%0d got=%0d want=0+/-64", rcvd, y_out); end
        checks++; if (dz > 65536 || dz < -65536) begin failures++; $display("FAIL b2b_z idx=%0d got=%h want=%h+/-2^16", rcvd, z_out, ez); end
        rcvd++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++; if (rcvd != 32) begin failures++; $display("FAIL b2b_count got=%0d want=32", rcvd); end
  endtask

  task automatic test_reset_inflight();
    int lat, xo, yo, seen;
    logic [31:0] zo;
    logic mo;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      mode = 1'b0;
      x_in = 16'sd16384;
      y_in = '0;
      z_in = 32'h20000000;
    end
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 0; n < 40 && !out_valid; n++) @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL inflight_head got=%b want=1", out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL async_reset_valid got=%b want=0", out_valid); end
    checks++; if (x_out !== '0) begin failures++; $display("FAIL async_reset_x got=%0d want=0", x_out); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%b want=1", in_ready); end
    out_ready = 1'b1;
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL flushed_emitted got=%0d want=0", seen); end
    run_one(1'b0, 16384, 0, 32'h20000000, lat, xo, yo, zo, mo);
    checks++; if (lat != LAT) begin failures++; $display("FAIL post_reset_latency got=%0d want=%0d", lat, LAT); end
    checks++; if (xo > R45 + 64 || xo < R45 - 64) begin failures++; $display("FAIL post_reset_x got=%0d want=%0d+/-64", xo, R45); end
    checks++; if (yo > R45 + 64 || yo < R45 - 64) begin failures++; $display("FAIL post_reset_y got=%0d want=%0d+/-64", yo, R45); end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_vectoring();
    test_back_to_back();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
